// File: rtl/and_gate_pkg.sv
// Shared types and constants for the and_gate primitive and its optional
// coverage counters.
package and_gate_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int COV_CNT_W     = 16;

    typedef logic [COV_CNT_W-1:0] cov_cnt_t;

    localparam cov_cnt_t COV_CNT_MAX = '1;

    // Input pattern {a[0], b[0]} used to select a coverage counter.
    typedef enum logic [1:0] {
        PAT_00 = 2'b00,
        PAT_01 = 2'b01,
        PAT_10 = 2'b10,
        PAT_11 = 2'b11
    } cov_pat_e;

    function automatic cov_cnt_t sat_inc(input cov_cnt_t cnt);
        return (cnt == COV_CNT_MAX) ? cnt : cnt + cov_cnt_t'(1);
    endfunction

endpackage

// File: rtl/and_gate_cov.sv
// Four saturating 16-bit counters, one per {a[0], b[0]} pattern, counting
// rising clk edges that carry a valid input.
module and_gate_cov
    import and_gate_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  logic     a0,
    input  logic     b0,
    output cov_cnt_t cnt00,
    output cov_cnt_t cnt01,
    output cov_cnt_t cnt10,
    output cov_cnt_t cnt11
);

    cov_cnt_t r_cnt [4];
    cov_pat_e w_pat;

    assign w_pat = cov_pat_e'({a0, b0});

    // NOTE: only four counters, so resetting the whole array is cheap and keeps every output defined out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (in_valid) begin
            r_cnt[w_pat] <= sat_inc(r_cnt[w_pat]);
        end
    end

    assign cnt00 = r_cnt[PAT_00];
    assign cnt01 = r_cnt[PAT_01];
    assign cnt10 = r_cnt[PAT_10];
    assign cnt11 = r_cnt[PAT_11];

endmodule

// File: rtl/and_gate.sv
// Parameterised bitwise AND with a combinational output and a one-cycle
// registered copy. Define AND_GATE_COV_EN to add pattern coverage counters.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             all_ones
`ifdef AND_GATE_COV_EN
    ,
    output cov_cnt_t         cnt00,
    output cov_cnt_t         cnt01,
    output cov_cnt_t         cnt10,
    output cov_cnt_t         cnt11
`endif
);

    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;

    assign y = a & b;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_q       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y_q <= a & b;
            end
        end
    end

    assign y_q       = r_y_q;
    assign out_valid = r_out_valid;
    assign all_ones  = r_out_valid & (&r_y_q);

`ifdef AND_GATE_COV_EN
    and_gate_cov u_cov (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a0       (a[0]),
        .b0       (b[0]),
        .cnt00    (cnt00),
        .cnt01    (cnt01),
        .cnt10    (cnt10),
        .cnt11    (cnt11)
    );
`endif

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: a 1-bit instance for the plain gate and an
// 8-bit instance for the registered path, with a behavioural reference model.
module tb_and_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a1 = 1'b0, b1 = 1'b0, iv1 = 1'b0;
    logic       y1, yq1, ov1, ao1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       iv8 = 1'b0;
    logic [7:0] y8, yq8;
    logic       ov8, ao8;

`ifdef AND_GATE_COV_EN
    logic [15:0] c1_00, c1_01, c1_10, c1_11;
    logic [15:0] c8_00, c8_01, c8_10, c8_11;
    int          m_cnt [4];
`endif

    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0] m_yq;
    logic       m_ov;

    always #5 clk = ~clk;

    and_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .in_valid(iv1),
        .y_q(yq1), .out_valid(ov1), .all_ones(ao1)
`ifdef AND_GATE_COV_EN
        , .cnt00(c1_00), .cnt01(c1_01), .cnt10(c1_10), .cnt11(c1_11)
`endif
    );

    and_gate #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .in_valid(iv8),
        .y_q(yq8), .out_valid(ov8), .all_ones(ao8)
`ifdef AND_GATE_COV_EN
        , .cnt00(c8_00), .cnt01(c8_01), .cnt10(c8_10), .cnt11(c8_11)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference for the registered path: one capture per valid edge.
    task automatic model_edge();
        if (rst) begin
            m_yq = '0;
            m_ov = 1'b0;
        end else if (iv8) begin
            m_yq = a8 & b8;
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        // Reset state, before any clock edge.
        #1;
        check("rst_yq8", yq8, 8'h00);
        check("rst_ov8", ov8, 1'b0);
        check("rst_ao8", ao8, 1'b0);
        check("rst_yq1", yq1, 1'b0);
        check("rst_ov1", ov1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Textbook truth table on the 1-bit instance, 10 ns per vector.
        for (int p = 0; p < 4; p++) begin
            logic [1:0] pat;
            pat = 2'(p);
            a1 = pat[1];
            b1 = pat[0];
            #1;
            check($sformatf("tt_%0d_settle", p), y1, (p == 3) ? 1'b1 : 1'b0);
            #8;
            check($sformatf("tt_%0d_stable", p), y1, (p == 3) ? 1'b1 : 1'b0);
            #1;
        end

        // F0 & 3C: combinational now, registered at the next edge.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h3C; iv8 = 1'b1;
        #1;
        check("f0_3c_y", y8, 8'h30);
        @(posedge clk); #1;
        check("f0_3c_yq", yq8, 8'h30);
        check("f0_3c_ov", ov8, 1'b1);
        check("f0_3c_ao", ao8, 1'b0);

        // All ones for one cycle, then in_valid drops and y_q holds.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        @(posedge clk); #1;
        check("ff_yq", yq8, 8'hFF);
        check("ff_ao", ao8, 1'b1);
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; iv8 = 1'b0;
        @(posedge clk); #1;
        check("ff_hold_yq", yq8, 8'hFF);
        check("ff_hold_ov", ov8, 1'b0);
        check("ff_hold_ao", ao8, 1'b0);

        // Asynchronous reset between edges while out_valid=1.
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'hFF; iv8 = 1'b1;
        @(posedge clk); #1;
        check("pre_arst_ov", ov8, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_yq", yq8, 8'h00);
        check("arst_ov", ov8, 1'b0);
        check("arst_ao", ao8, 1'b0);
        a8 = 8'h5A;
        #1;
        check("arst_y_follows", y8, 8'h5A);
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'h81; b8 = 8'hC3;
        @(posedge clk); #1;
        check("post_rst_yq", yq8, 8'h81);
        check("post_rst_ov", ov8, 1'b1);

        // Reset held across a valid edge: reset wins.
        @(negedge clk);
        rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        @(posedge clk); #1;
        check("rst_wins_yq", yq8, 8'h00);
        check("rst_wins_ov", ov8, 1'b0);
        m_yq = '0;
        m_ov = 1'b0;

        // Randomised traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            iv8 = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 19) == 0);
            #1;
            check("rnd_y", y8, a8 & b8);
            @(posedge clk);
            model_edge();
            #1;
            check("rnd_yq", yq8, m_yq);
            check("rnd_ov", ov8, m_ov);
            check("rnd_ao", ao8, (m_ov && m_yq == 8'hFF) ? 1'b1 : 1'b0);
        end
        check("w1_ov_never", ov1, 1'b0);
        check("w1_ao_never", ao1, 1'b0);

`ifdef AND_GATE_COV_EN
        // Four patterns, three rounds each, from a clean reset.
        @(negedge clk);
        rst = 1'b1; iv8 = 1'b0;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) begin
                logic [1:0] pat;
                pat = 2'(p);
                @(negedge clk);
                a8 = {7'($urandom), pat[1]};
                b8 = {7'($urandom), pat[0]};
                iv8 = 1'b1;
                m_cnt[p] = m_cnt[p] + 1;
            end
        end
        @(negedge clk);
        iv8 = 1'b0;
        check("cov_cnt00", c8_00, 16'(m_cnt[0]));
        check("cov_cnt01", c8_01, 16'(m_cnt[1]));
        check("cov_cnt10", c8_10, 16'(m_cnt[2]));
        check("cov_cnt11", c8_11, 16'(m_cnt[3]));
        check("cov_cnt11_is3", c8_11, 16'd3);
        rst = 1'b1;
        #1;
        check("cov_rst00", c8_00, 16'd0);
        check("cov_rst01", c8_01, 16'd0);
        check("cov_rst10", c8_10, 16'd0);
        check("cov_rst11", c8_11, 16'd0);
        #1;
        rst = 1'b0;

        // Saturation: 70000 valid (1,1) edges.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        check("cov_sat11", c8_11, 16'hFFFF);
        check("cov_sat00", c8_00, 16'd0);
        check("cov_w1_idle", {c1_00, c1_01, c1_10, c1_11}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
